// File: rtl/equiv_if.sv
// Bundle between the two DUT output buses and the equivalence monitor.
// The wrapper drives the compare inputs and reads back the results.
interface equiv_if #(
  parameter int WIDTH = 91,
  parameter int CNT_W = 16
);
  logic             en;
  logic             clear;
  logic [WIDTH-1:0] y_a;
  logic [WIDTH-1:0] y_b;
  logic             fail;
  logic [CNT_W-1:0] mismatch_cnt;
  logic [CNT_W-1:0] compare_cnt;
  logic [CNT_W-1:0] first_idx;
  logic [WIDTH-1:0] first_diff;
  logic             checking;

  modport master (
    output en, clear, y_a, y_b,
    input  fail, mismatch_cnt, compare_cnt, first_idx, first_diff, checking
  );

  modport slave (
    input  en, clear, y_a, y_b,
    output fail, mismatch_cnt, compare_cnt, first_idx, first_diff, checking
  );
endinterface

// File: rtl/equiv_monitor.sv
// Cycle-by-cycle equivalence monitor: per-side latency realignment, sticky fail,
// saturating mismatch/compare counters and capture of the first divergence.

module equiv_delay #(
  parameter int WIDTH = 91,
  parameter int DEPTH = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign dout = din;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
        stage[0] <= din;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign dout = stage[DEPTH-1];
  end
endmodule

// state  | meaning
// WARMUP | waiting SETTLE edges after reset so delay lines hold real data
// CHECK  | comparing a_d against b_d on every en cycle
// HALT   | first mismatch seen with STOP_ON_FAIL; results frozen until clear
module equiv_monitor #(
  parameter int WIDTH        = 91,
  parameter int DELAY_A      = 0,
  parameter int DELAY_B      = 0,
  parameter int SETTLE       = 8,
  parameter int CNT_W        = 16,
  parameter bit STOP_ON_FAIL = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  equiv_if.slave   bus
);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  if (DELAY_A < 0 || DELAY_A > 8 || DELAY_B < 0 || DELAY_B > 8) begin : g_bad_delay
    $error("equiv_monitor: delays must lie in 0..8");
  end
  if (SETTLE < DELAY_A || SETTLE < DELAY_B) begin : g_bad_settle
    $error("equiv_monitor: SETTLE must cover the longest delay line");
  end

  typedef enum logic [1:0] {WARMUP, CHECK, HALT} state_t;

  state_t           state, state_nxt;
  logic [SW-1:0]    settle_cnt, settle_nxt;
  logic             fail_q, fail_nxt;
  logic [CNT_W-1:0] mm_q, mm_nxt;
  logic [CNT_W-1:0] cmp_q, cmp_nxt;
  logic [CNT_W-1:0] idx_q, idx_nxt;
  logic [WIDTH-1:0] diff_q, diff_nxt;

  logic [WIDTH-1:0] a_d, b_d, diff;
  logic             diverge;

  equiv_delay #(.WIDTH(WIDTH), .DEPTH(DELAY_A)) u_dly_a (
    .clk(clk), .rst(rst), .din(bus.y_a), .dout(a_d)
  );
  equiv_delay #(.WIDTH(WIDTH), .DEPTH(DELAY_B)) u_dly_b (
    .clk(clk), .rst(rst), .din(bus.y_b), .dout(b_d)
  );

  assign diff    = a_d ^ b_d;
  assign diverge = |diff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= WARMUP;
      settle_cnt <= SW'(SETTLE);
      fail_q     <= 1'b0;
      mm_q       <= '0;
      cmp_q      <= '0;
      idx_q      <= '0;
      diff_q     <= '0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
      fail_q     <= fail_nxt;
      mm_q       <= mm_nxt;
      cmp_q      <= cmp_nxt;
      idx_q      <= idx_nxt;
      diff_q     <= diff_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    fail_nxt   = fail_q;
    mm_nxt     = mm_q;
    cmp_nxt    = cmp_q;
    idx_nxt    = idx_q;
    diff_nxt   = diff_q;

    unique case (state)
      WARMUP: begin
        // Down-counter reaches terminal count on the SETTLE-th edge (or at once for 0).
        if (settle_cnt <= SW'(1)) state_nxt = CHECK;
        else                      settle_nxt = settle_cnt - SW'(1);
      end
      CHECK, HALT: begin
        if (bus.clear) begin
          fail_nxt  = 1'b0;
          mm_nxt    = '0;
          cmp_nxt   = '0;
          idx_nxt   = '0;
          diff_nxt  = '0;
          state_nxt = CHECK;
        end else if (state == CHECK && bus.en) begin
          if (cmp_q != CNT_MAX) cmp_nxt = cmp_q + CNT_W'(1);
          if (diverge) begin
            fail_nxt = 1'b1;
            if (mm_q != CNT_MAX) mm_nxt = mm_q + CNT_W'(1);
            if (!fail_q) begin
              idx_nxt  = cmp_q;
              diff_nxt = diff;
            end
            if (STOP_ON_FAIL) state_nxt = HALT;
          end
        end
      end
      default: state_nxt = WARMUP;
    endcase
  end

  assign bus.fail         = fail_q;
  assign bus.mismatch_cnt = mm_q;
  assign bus.compare_cnt  = cmp_q;
  assign bus.first_idx    = idx_q;
  assign bus.first_diff   = diff_q;
  assign bus.checking     = (state == CHECK);
endmodule

// File: tb/tb_equiv_monitor.sv
// Bench for equiv_monitor: five parameter variants share one stimulus stream and
// are checked every cycle against a history-queue reference model.
module tb_equiv_monitor;
  localparam int W        = 91;
  localparam int NI       = 5;
  localparam int SETTLE_P = 8;

  // 0: default stop-on-fail, 1: keep counting, 2: B lags A cancelled,
  // 3: delay on wrong side, 4: 4-bit saturating counters
  function automatic int da(input int i); return (i == 2) ? 3 : 0; endfunction
  function automatic int db(input int i); return (i == 3) ? 3 : 0; endfunction
  function automatic bit stp(input int i); return !(i == 1 || i == 4); endfunction
  function automatic int cw(input int i); return (i == 4) ? 4 : 16; endfunction

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic clear = 1'b0;
  logic [W-1:0] ya [NI];
  logic [W-1:0] yb [NI];

  logic         o_fail [NI];
  logic         o_chk  [NI];
  logic [15:0]  o_mm   [NI];
  logic [15:0]  o_cmp  [NI];
  logic [15:0]  o_idx  [NI];
  logic [W-1:0] o_diff [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_inst
    equiv_if #(.WIDTH(W), .CNT_W(cw(g))) bus ();
    assign bus.en    = en;
    assign bus.clear = clear;
    assign bus.y_a   = ya[g];
    assign bus.y_b   = yb[g];

    equiv_monitor #(
      .WIDTH(W), .DELAY_A(da(g)), .DELAY_B(db(g)), .SETTLE(SETTLE_P),
      .CNT_W(cw(g)), .STOP_ON_FAIL(stp(g))
    ) dut (
      .clk(clk), .rst(rst), .bus(bus)
    );

    assign o_fail[g] = bus.fail;
    assign o_chk[g]  = bus.checking;
    assign o_mm[g]   = 16'(bus.mismatch_cnt);
    assign o_cmp[g]  = 16'(bus.compare_cnt);
    assign o_idx[g]  = 16'(bus.first_idx);
    assign o_diff[g] = bus.first_diff;
  end

  // reference model: mode 0 warmup, 1 comparing, 2 halted
  int           m_mode [NI];
  int           m_e    [NI];
  logic         m_fail [NI];
  int           m_mm   [NI];
  int           m_cmp  [NI];
  int           m_idx  [NI];
  logic [W-1:0] m_diff [NI];
  logic [W-1:0] qa [NI][$];
  logic [W-1:0] qb [NI][$];
  logic [W-1:0] lagq [$];

  int n_pass = 0;
  int n_tot  = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_mode[i] = 0; m_e[i] = 0; m_fail[i] = 1'b0;
      m_mm[i] = 0; m_cmp[i] = 0; m_idx[i] = 0; m_diff[i] = '0;
      qa[i].delete(); qb[i].delete();
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NI; i++) begin
      logic [W-1:0] ad, bd, d;
      int mx;
      qa[i].push_back(ya[i]);
      qb[i].push_back(yb[i]);
      if (qa[i].size() > 9) void'(qa[i].pop_front());
      if (qb[i].size() > 9) void'(qb[i].pop_front());
      ad = (qa[i].size() > da(i)) ? qa[i][qa[i].size() - 1 - da(i)] : '0;
      bd = (qb[i].size() > db(i)) ? qb[i][qb[i].size() - 1 - db(i)] : '0;
      d  = ad ^ bd;
      mx = (1 << cw(i)) - 1;
      if (m_mode[i] == 0) begin
        m_e[i]++;
        if (m_e[i] >= SETTLE_P) m_mode[i] = 1;
      end else if (clear) begin
        m_fail[i] = 1'b0; m_mm[i] = 0; m_cmp[i] = 0; m_idx[i] = 0; m_diff[i] = '0;
        m_mode[i] = 1;
      end else if (m_mode[i] == 1 && en) begin
        if (d != '0) begin
          if (!m_fail[i]) begin
            m_idx[i]  = m_cmp[i];
            m_diff[i] = d;
          end
          m_fail[i] = 1'b1;
          if (m_mm[i] < mx) m_mm[i]++;
          if (stp(i)) m_mode[i] = 2;
        end
        if (m_cmp[i] < mx) m_cmp[i]++;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("i%0d fail", i),     128'(o_fail[i]), 128'(m_fail[i]));
      check($sformatf("i%0d mm_cnt", i),   128'(o_mm[i]),   128'(m_mm[i]));
      check($sformatf("i%0d cmp_cnt", i),  128'(o_cmp[i]),  128'(m_cmp[i]));
      check($sformatf("i%0d first_idx", i), 128'(o_idx[i]), 128'(m_idx[i]));
      check($sformatf("i%0d first_diff", i), 128'(o_diff[i]), 128'(m_diff[i]));
      check($sformatf("i%0d checking", i), 128'(o_chk[i]),  128'(m_mode[i] == 1));
    end
  endtask

  // New random word for every side; inst 2/3 see B lagging A by three cycles.
  task automatic drive(input logic [W-1:0] flip01);
    logic [W-1:0] r, lag;
    r   = W'({$urandom(), $urandom(), $urandom()});
    lag = (lagq.size() >= 3) ? lagq[lagq.size() - 3] : '0;
    lagq.push_back(r);
    if (lagq.size() > 8) void'(lagq.pop_front());
    ya[0] = r; yb[0] = r ^ flip01;
    ya[1] = r; yb[1] = r ^ flip01;
    ya[2] = r; yb[2] = lag;
    ya[3] = r; yb[3] = lag;
    ya[4] = r; yb[4] = ~r;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic random_step();
    logic [W-1:0] f;
    en    = ($urandom_range(0, 3) != 0);
    clear = ($urandom_range(0, 19) == 0);
    f = '0;
    if ($urandom_range(0, 7) == 0) f[$urandom_range(0, W - 1)] = 1'b1;
    drive(f);
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < NI; i++) begin ya[i] = '0; yb[i] = '0; end
    model_reset();
    #1 rst = 1'b1;
    #1 check_all();
    drive('0); tick();
    drive('0); tick();
    rst = 1'b0;

    en = 1'b1;
    for (int k = 1; k <= SETTLE_P; k++) begin
      drive('0);
      tick();
      if (k == SETTLE_P - 1) check("warmup checking low", 128'(o_chk[0]), 128'(0));
    end
    check("checking after settle", 128'(o_chk[0]), 128'(1));

    for (int k = 1; k <= 100; k++) begin
      drive((k == 5 || k == 10) ? W'(8) : W'(0));
      tick();
      if (k == 5) begin
        check("stop fail",      128'(o_fail[0]), 128'(1));
        check("stop first_idx", 128'(o_idx[0]),  128'(4));
        check("stop first_diff", 128'(o_diff[0]), 128'(8));
        check("stop cmp_cnt",   128'(o_cmp[0]),  128'(5));
        check("stop mm_cnt",    128'(o_mm[0]),   128'(1));
      end
    end
    check("halt frozen cmp",   128'(o_cmp[0]),  128'(5));
    check("run mm_cnt",        128'(o_mm[1]),   128'(2));
    check("run first_idx",     128'(o_idx[1]),  128'(4));
    check("run cmp_cnt",       128'(o_cmp[1]),  128'(100));
    check("aligned mm_cnt",    128'(o_mm[2]),   128'(0));
    check("aligned cmp_cnt",   128'(o_cmp[2]),  128'(100));
    check("aligned fail",      128'(o_fail[2]), 128'(0));
    check("misaligned fail",   128'(o_fail[3]), 128'(1));
    check("sat cmp_cnt",       128'(o_cmp[4]),  128'(15));
    check("sat mm_cnt",        128'(o_mm[4]),   128'(15));
    check("sat fail",          128'(o_fail[4]), 128'(1));

    clear = 1'b1;
    drive(W'(8));
    tick();
    clear = 1'b0;
    check("clear fail",      128'(o_fail[0]), 128'(0));
    check("clear cmp_cnt",   128'(o_cmp[0]),  128'(0));
    check("clear mm_cnt",    128'(o_mm[0]),   128'(0));
    check("clear first_diff", 128'(o_diff[0]), 128'(0));
    check("clear checking",  128'(o_chk[0]),  128'(1));

    for (int k = 0; k < 60; k++) random_step();

    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    check("async rst checking", 128'(o_chk[2]), 128'(0));
    check("async rst cmp_cnt",  128'(o_cmp[2]), 128'(0));
    drive('0); tick();
    rst = 1'b0;
    clear = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      random_step();
      if (k == SETTLE_P - 1) check("rewarm checking low", 128'(o_chk[2]), 128'(0));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
